// File: rtl/sparc_mem_responder.sv
// Memory-side responder for the MOV/MOC handshake: latches a request, waits
// WAIT_CYCLES, performs a big-endian byte/halfword/word access and answers with MOC.
module sparc_mem_responder #(
  parameter int MEM_BYTES   = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        Err
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  logic [7:0] Mem [0:MEM_BYTES-1];

  state_t      state, state_nx;
  logic [3:0]  cnt_p0, cnt_nx;
  logic        accept, access;

  logic        rw_p0;
  logic [1:0]  size_p0;
  logic        sext_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;

  logic          req_err;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [31:0]   rd_raw;

  function automatic logic [31:0] extend(input logic [31:0] raw,
                                         input logic [1:0]  sz,
                                         input logic        sx);
    case (sz)
      2'b00:   return {{24{sx & raw[7]}}, raw[7:0]};
      2'b01:   return {{16{sx & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Last byte is computed with a carry bit so addresses near 2^32 cannot wrap into range.
  function automatic logic access_error(input logic [31:0] a, input logic [1:0] sz);
    logic [32:0] last;
    logic        bad;
    bad  = 1'b0;
    last = {1'b0, a};
    case (sz)
      2'b00: last = {1'b0, a};
      2'b01: begin
        bad  = a[0];
        last = {1'b0, a} + 33'd1;
      end
      2'b10: begin
        bad  = (a[1:0] != 2'b00);
        last = {1'b0, a} + 33'd3;
      end
      default: bad = 1'b1;
    endcase
    return bad | (last >= 33'(MEM_BYTES));
  endfunction

  assign req_err = access_error(addr_p0, size_p0);
  assign MOC     = (state == ST_ACK);

  always_comb begin
    idx0 = addr_p0[AW-1:0];
    idx1 = idx0 + AW'(1);
    idx2 = idx0 + AW'(2);
    idx3 = idx0 + AW'(3);
    case (size_p0)
      2'b00:   rd_raw = {24'd0, Mem[idx0]};
      2'b01:   rd_raw = {16'd0, Mem[idx0], Mem[idx1]};
      default: rd_raw = {Mem[idx0], Mem[idx1], Mem[idx2], Mem[idx3]};
    endcase
  end

  // The accepting edge is not itself a wait state: the access happens WAIT_CYCLES+1
  // edges after MOV is latched, so a zero-wait configuration still answers one edge later.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_p0;
    accept   = 1'b0;
    access   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (MOV) begin
          accept   = 1'b1;
          cnt_nx   = 4'd0;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_p0 == 4'(WAIT_CYCLES)) begin
          access   = 1'b1;
          state_nx = ST_ACK;
        end else begin
          cnt_nx = cnt_p0 + 4'd1;
        end
      end
      ST_ACK: begin
        if (!MOV) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Stage p0: request capture (data only, no reset needed)
  always_ff @(posedge Clk) begin
    if (accept) begin
      rw_p0    <= RW;
      size_p0  <= Size;
      sext_p0  <= SignExt;
      addr_p0  <= Address;
      wdata_p0 <= DataIn;
    end
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state   <= ST_IDLE;
      cnt_p0  <= 4'd0;
      Err     <= 1'b0;
      DataOut <= 32'd0;
    end else begin
      state  <= state_nx;
      cnt_p0 <= cnt_nx;
      if (access) begin
        Err <= req_err;
        if (req_err)    DataOut <= 32'd0;
        else if (rw_p0) DataOut <= extend(rd_raw, size_p0, sext_p0);
      end else if (state == ST_ACK && !MOV) begin
        Err <= 1'b0;
      end
    end
  end

  // Stage p1: array commit; a reset on the commit edge suppresses the write
  always_ff @(posedge Clk) begin
    if (access && !RESET && !rw_p0 && !req_err) begin
      case (size_p0)
        2'b00: Mem[idx0] <= wdata_p0[7:0];
        2'b01: begin
          Mem[idx0] <= wdata_p0[15:8];
          Mem[idx1] <= wdata_p0[7:0];
        end
        default: begin
          Mem[idx0] <= wdata_p0[31:24];
          Mem[idx1] <= wdata_p0[23:16];
          Mem[idx2] <= wdata_p0[15:8];
          Mem[idx3] <= wdata_p0[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sparc_mem_responder.sv
// Bench for sparc_mem_responder: byte-array reference model with a per-cycle
// output compare, literal spot checks, and randomized request traffic.
module tb_sparc_mem_responder;
  localparam int MB = 512;
  localparam int W  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mov, rw, sext;
  logic [1:0]  size;
  logic [31:0] addr, din, dout;
  logic        moc, err;

  logic        mov0, rw0, sext0;
  logic [1:0]  size0;
  logic [31:0] addr0, din0, dout0;
  logic        moc0, err0;

  sparc_mem_responder #(.MEM_BYTES(MB), .WAIT_CYCLES(W)) dut (
    .Clk(clk), .RESET(rst), .MOV(mov), .RW(rw), .Size(size), .SignExt(sext),
    .Address(addr), .DataIn(din), .DataOut(dout), .MOC(moc), .Err(err));

  sparc_mem_responder #(.MEM_BYTES(MB), .WAIT_CYCLES(0)) dut0 (
    .Clk(clk), .RESET(rst), .MOV(mov0), .RW(rw0), .Size(size0), .SignExt(sext0),
    .Address(addr0), .DataIn(din0), .DataOut(dout0), .MOC(moc0), .Err(err0));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mm [MB];
  logic        exp_moc, exp_err;
  logic [31:0] exp_dout;
  bit          cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("moc_cycle", 32'(moc), 32'(exp_moc));
      chk("err_cycle", 32'(err), 32'(exp_err));
      chk("dout_cycle", dout, exp_dout);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_err(input logic [31:0] a, input logic [1:0] s);
    int nb;
    if (s == 2'b11) return 1'b1;
    nb = 1 << s;
    if ((a % nb) != 0) return 1'b1;
    if (a >= MB) return 1'b1;
    return (int'(a) + nb - 1 >= MB);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] s, input logic sx);
    int nb;
    longint v;
    nb = 1 << s;
    v = 0;
    for (int i = 0; i < nb; i++) v = v * 256 + longint'(mm[int'(a) + i]);
    if (sx && nb < 4 && v >= (64'sd1 <<< (8 * nb - 1))) v = v - (64'sd1 <<< (8 * nb));
    return 32'(v);
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    int nb;
    nb = 1 << s;
    for (int i = 0; i < nb; i++) mm[int'(a) + i] = 8'(d >> (8 * (nb - 1 - i)));
  endtask

  // One full handshake on the W-wait instance; returns outputs seen just after the commit edge.
  task automatic txn(input logic r, input logic [1:0] s, input logic sx,
                     input logic [31:0] a, input logic [31:0] d,
                     input int hold, input bit drop,
                     output logic [31:0] got_dout, output logic got_err);
    bit e;
    logic [31:0] rd;
    mov = 1'b1; rw = r; size = s; sext = sx; addr = a; din = d;
    tick();
    e  = m_err(a, s);
    rd = (!e && r) ? m_read(a, s, sx) : 32'd0;
    rw = 1'($urandom); size = 2'($urandom); sext = 1'($urandom);
    addr = $urandom; din = $urandom;
    if (drop) mov = 1'b0;
    repeat (W) tick();
    tick();
    exp_moc = 1'b1;
    exp_err = e;
    if (e)      exp_dout = 32'd0;
    else if (r) exp_dout = rd;
    else        m_write(a, s, d);
    got_dout = dout;
    got_err  = err;
    if (!drop) begin
      repeat (hold) tick();
      mov = 1'b0;
    end
    tick();
    exp_moc = 1'b0;
    exp_err = 1'b0;
  endtask

  logic [31:0] gd;
  logic        ge;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mov = 0; rw = 0; sext = 0; size = 0; addr = 0; din = 0;
    mov0 = 0; rw0 = 0; sext0 = 0; size0 = 0; addr0 = 0; din0 = 0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_moc", 32'(moc), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_dout", dout, 32'd0);
    chk("reset_moc_w0", 32'(moc0), 32'd0);
    exp_moc = 1'b0; exp_err = 1'b0; exp_dout = 32'd0;
    cmp_en = 1'b1;

    for (int a = 0; a < MB; a += 4) txn(1'b0, 2'b10, 1'b0, 32'(a), $urandom, 0, 1'b0, gd, ge);

    // Word write/read and exact MOC latency
    mov = 1'b1; rw = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'd8; din = 32'hDEADBEEF;
    tick();
    mov = 1'b1; din = 32'h0;
    tick(); chk("t1_moc_k1", 32'(moc), 32'd0);
    tick(); chk("t1_moc_k2", 32'(moc), 32'd0);
    tick(); chk("t1_moc_k3", 32'(moc), 32'd1);
    m_write(32'd8, 2'b10, 32'hDEADBEEF);
    exp_moc = 1'b1;
    mov = 1'b0;
    tick();
    exp_moc = 1'b0;
    chk("t1_mem", {dut.Mem[8], dut.Mem[9], dut.Mem[10], dut.Mem[11]}, 32'hDEADBEEF);
    txn(1'b1, 2'b10, 1'b0, 32'd8, 32'd0, 0, 1'b0, gd, ge);
    chk("t1_read", gd, 32'hDEADBEEF);
    chk("t1_err", 32'(ge), 32'd0);

    // Byte/halfword extension
    txn(1'b0, 2'b00, 1'b0, 32'd16, 32'h11111180, 0, 1'b0, gd, ge);
    txn(1'b0, 2'b00, 1'b0, 32'd17, 32'h2222227F, 1, 1'b0, gd, ge);
    chk("t2_model_pin", m_read(32'd16, 2'b01, 1'b1), 32'hFFFF807F);
    txn(1'b1, 2'b00, 1'b1, 32'd16, 32'd0, 0, 1'b0, gd, ge);
    chk("t2_byte_sx", gd, 32'hFFFFFF80);
    txn(1'b1, 2'b00, 1'b0, 32'd16, 32'd0, 0, 1'b0, gd, ge);
    chk("t2_byte_zx", gd, 32'h00000080);
    txn(1'b1, 2'b01, 1'b1, 32'd16, 32'd0, 0, 1'b0, gd, ge);
    chk("t2_half_sx", gd, 32'hFFFF807F);
    txn(1'b1, 2'b01, 1'b0, 32'd16, 32'd0, 0, 1'b0, gd, ge);
    chk("t2_half_zx", gd, 32'h0000807F);

    // Misalignment, illegal size and range
    txn(1'b1, 2'b10, 1'b0, 32'd6, 32'd0, 0, 1'b0, gd, ge);
    chk("t3_word6_err", 32'(ge), 32'd1);
    chk("t3_word6_dout", gd, 32'd0);
    txn(1'b0, 2'b01, 1'b0, 32'd5, 32'h0000ABCD, 0, 1'b0, gd, ge);
    chk("t3_half5_err", 32'(ge), 32'd1);
    chk("t3_half5_mem", {24'd0, dut.Mem[5]}, {24'd0, mm[5]});
    txn(1'b1, 2'b11, 1'b0, 32'd0, 32'd0, 0, 1'b0, gd, ge);
    chk("t3_size11_err", 32'(ge), 32'd1);
    txn(1'b1, 2'b10, 1'b0, 32'd510, 32'd0, 0, 1'b0, gd, ge);
    chk("t4_word510_err", 32'(ge), 32'd1);
    txn(1'b1, 2'b00, 1'b0, 32'd511, 32'd0, 0, 1'b0, gd, ge);
    chk("t4_byte511_err", 32'(ge), 32'd0);
    chk("t4_byte511_dout", gd, {24'd0, mm[511]});
    txn(1'b1, 2'b00, 1'b0, 32'd512, 32'd0, 0, 1'b0, gd, ge);
    chk("t4_byte512_err", 32'(ge), 32'd1);

    // Held MOV and dropped MOV
    txn(1'b0, 2'b10, 1'b0, 32'd32, 32'h0BADF00D, 5, 1'b0, gd, ge);
    chk("t5_hold_mem", {dut.Mem[32], dut.Mem[33], dut.Mem[34], dut.Mem[35]}, 32'h0BADF00D);
    txn(1'b0, 2'b10, 1'b0, 32'd36, 32'h5A5AA5A5, 0, 1'b1, gd, ge);
    chk("t5_drop_mem", {dut.Mem[36], dut.Mem[37], dut.Mem[38], dut.Mem[39]}, 32'h5A5AA5A5);

    // Zero-wait instance answers one edge after acceptance
    mov0 = 1'b1; rw0 = 1'b0; size0 = 2'b10; addr0 = 32'h40; din0 = 32'hCAFEF00D;
    tick(); chk("w0_moc_k", 32'(moc0), 32'd0);
    din0 = 32'd0;
    tick(); chk("w0_moc_k1", 32'(moc0), 32'd1);
    chk("w0_err", 32'(err0), 32'd0);
    mov0 = 1'b0;
    tick(); chk("w0_moc_clr", 32'(moc0), 32'd0);
    mov0 = 1'b1; rw0 = 1'b1;
    tick(); tick();
    chk("w0_read", dout0, 32'hCAFEF00D);
    mov0 = 1'b0;
    tick();

    // Reset on the commit edge cancels the write
    txn(1'b0, 2'b10, 1'b0, 32'd0, 32'hA1B2C3D4, 0, 1'b0, gd, ge);
    mov = 1'b1; rw = 1'b0; size = 2'b10; addr = 32'd0; din = 32'h12345678;
    tick();
    repeat (W) tick();
    rst = 1'b1;
    tick();
    exp_moc = 1'b0; exp_err = 1'b0; exp_dout = 32'd0;
    chk("t6_moc", 32'(moc), 32'd0);
    chk("t6_mem", {dut.Mem[0], dut.Mem[1], dut.Mem[2], dut.Mem[3]}, 32'hA1B2C3D4);
    rst = 1'b0; mov = 1'b0;
    tick();
    txn(1'b1, 2'b10, 1'b0, 32'd0, 32'd0, 0, 1'b0, gd, ge);
    chk("t6_after", gd, 32'hA1B2C3D4);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      logic        r, sx;
      logic [1:0]  s;
      logic [31:0] a;
      int          pick;
      r    = 1'($urandom_range(0, 1));
      sx   = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 9);
      s    = (pick == 0) ? 2'b11 : 2'(pick % 3);
      a    = 32'($urandom_range(0, MB + 8));
      if (s != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~32'((1 << s) - 1);
      txn(r, s, sx, a, $urandom, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), gd, ge);
    end

    begin
      int bad;
      bad = 0;
      for (int i = 0; i < MB; i++) if (dut.Mem[i] !== mm[i]) bad++;
      chk("mem_dump_bad_bytes", 32'(bad), 32'd0);
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
